// File: rtl/fetch_queue.sv
// Dual-wide IF->ID instruction queue: circular buffer taking 0-2 fetched
// instructions per cycle and presenting the two oldest to decode in program order.
module fetch_queue #(
    parameter int DEPTH    = 8,
    parameter int PC_WIDTH = 32,
    parameter int ILEN     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       enq_valid_0,
    input  logic                       enq_valid_1,
    input  logic [PC_WIDTH-1:0]        enq_pc_0,
    input  logic [PC_WIDTH-1:0]        enq_pc_1,
    input  logic [ILEN-1:0]            enq_instr_0,
    input  logic [ILEN-1:0]            enq_instr_1,
    input  logic                       enq_pred_taken,
    input  logic [PC_WIDTH-1:0]        enq_pred_target,
    output logic                       enq_ready,
    output logic                       deq_valid_0,
    output logic                       deq_valid_1,
    output logic [PC_WIDTH-1:0]        deq_pc_0,
    output logic [PC_WIDTH-1:0]        deq_pc_1,
    output logic [ILEN-1:0]            deq_instr_0,
    output logic [ILEN-1:0]            deq_instr_1,
    output logic                       deq_pred_taken_0,
    output logic                       deq_pred_taken_1,
    output logic [PC_WIDTH-1:0]        deq_pred_target_0,
    output logic [PC_WIDTH-1:0]        deq_pred_target_1,
    input  logic [1:0]                 deq_count,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_WIDTH-1:0] pc_q     [DEPTH];
    logic [ILEN-1:0]     instr_q  [DEPTH];
    logic                ptaken_q [DEPTH];
    logic [PC_WIDTH-1:0] ptgt_q   [DEPTH];

    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW-1:0] head_nx, wr1_idx;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] n_enq, n_deq, deq_req;
    logic          enq_fire, wr0_en, wr1_en;

    // Credit is taken from the registered occupancy only, so deq_count never
    // reaches the IF stall path combinationally.
    assign enq_ready = count_q <= CW'(DEPTH - 2);
    assign enq_fire  = enq_ready && !flush;
    assign wr0_en    = enq_fire && enq_valid_0;
    assign wr1_en    = enq_fire && enq_valid_1;
    // Slot 1 is compacted onto tail when slot 0 is empty.
    assign wr1_idx   = tail_q + AW'(wr0_en);
    assign head_nx   = head_q + AW'(1);

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        n_enq   = CW'(wr0_en) + CW'(wr1_en);
        deq_req = (deq_count == 2'd3) ? CW'(2) : CW'(deq_count);
        n_deq   = (deq_req > count_q) ? count_q : deq_req;
        head_d  = head_q + AW'(n_deq);
        tail_d  = tail_q + AW'(n_enq);
        count_d = count_q + n_enq - n_deq;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; storage is
    // deliberately reset here because the cleared deq_* data is visible after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]     <= '0;
                instr_q[i]  <= '0;
                ptaken_q[i] <= 1'b0;
                ptgt_q[i]   <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (wr0_en) begin
                pc_q[tail_q]     <= enq_pc_0;
                instr_q[tail_q]  <= enq_instr_0;
                ptaken_q[tail_q] <= enq_pred_taken;
                ptgt_q[tail_q]   <= enq_pred_target;
            end
            // The predictor only annotates slot 0; slot 1 carries no prediction.
            if (wr1_en) begin
                pc_q[wr1_idx]     <= enq_pc_1;
                instr_q[wr1_idx]  <= enq_instr_1;
                ptaken_q[wr1_idx] <= 1'b0;
                ptgt_q[wr1_idx]   <= '0;
            end
        end
    end

    assign count             = count_q;
    assign deq_valid_0       = count_q >= CW'(1);
    assign deq_valid_1       = count_q >= CW'(2);
    assign deq_pc_0          = pc_q[head_q];
    assign deq_pc_1          = pc_q[head_nx];
    assign deq_instr_0       = instr_q[head_q];
    assign deq_instr_1       = instr_q[head_nx];
    assign deq_pred_taken_0  = ptaken_q[head_q];
    assign deq_pred_taken_1  = ptaken_q[head_nx];
    assign deq_pred_target_0 = ptgt_q[head_q];
    assign deq_pred_target_1 = ptgt_q[head_nx];

    // Decode may never consume more than is presented; the hardware clamps anyway.
    deq_count_legal: assert property (@(posedge clk) disable iff (rst)
        !flush |-> (deq_count != 2'd3 && CW'(deq_count) <= count_q))
        else $error("fetch_queue: illegal deq_count %0d with count %0d", deq_count, count_q);

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 8;
    localparam int PW    = 32;
    localparam int IL    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk, rst, flush;
    logic          enq_valid_0, enq_valid_1;
    logic [PW-1:0] enq_pc_0, enq_pc_1;
    logic [IL-1:0] enq_instr_0, enq_instr_1;
    logic          enq_pred_taken;
    logic [PW-1:0] enq_pred_target;
    logic          enq_ready;
    logic          deq_valid_0, deq_valid_1;
    logic [PW-1:0] deq_pc_0, deq_pc_1;
    logic [IL-1:0] deq_instr_0, deq_instr_1;
    logic          deq_pred_taken_0, deq_pred_taken_1;
    logic [PW-1:0] deq_pred_target_0, deq_pred_target_1;
    logic [1:0]    deq_count;
    logic [CW-1:0] count;

    fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(PW), .ILEN(IL)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid_0(enq_valid_0), .enq_valid_1(enq_valid_1),
        .enq_pc_0(enq_pc_0), .enq_pc_1(enq_pc_1),
        .enq_instr_0(enq_instr_0), .enq_instr_1(enq_instr_1),
        .enq_pred_taken(enq_pred_taken), .enq_pred_target(enq_pred_target),
        .enq_ready(enq_ready),
        .deq_valid_0(deq_valid_0), .deq_valid_1(deq_valid_1),
        .deq_pc_0(deq_pc_0), .deq_pc_1(deq_pc_1),
        .deq_instr_0(deq_instr_0), .deq_instr_1(deq_instr_1),
        .deq_pred_taken_0(deq_pred_taken_0), .deq_pred_taken_1(deq_pred_taken_1),
        .deq_pred_target_0(deq_pred_target_0), .deq_pred_target_1(deq_pred_target_1),
        .deq_count(deq_count), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] pc;
        logic [IL-1:0] instr;
        logic          pt;
        logic [PW-1:0] tgt;
    } entry_t;

    entry_t mq[$];
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Reference: occupancy is the queue length; entries leave from the front, arrive at the back.
    task automatic model_edge();
        int     nd;
        bit     rdy;
        entry_t e;
        if (flush) begin
            mq.delete();
        end else begin
            rdy = (DEPTH - mq.size()) >= 2;
            nd  = imin(int'(deq_count), mq.size());
            repeat (nd) void'(mq.pop_front());
            if (rdy && enq_valid_0) begin
                e = '{enq_pc_0, enq_instr_0, enq_pred_taken, enq_pred_target};
                mq.push_back(e);
            end
            if (rdy && enq_valid_1) begin
                e = '{enq_pc_1, enq_instr_1, 1'b0, '0};
                mq.push_back(e);
            end
        end
    endtask

    task automatic compare_all();
        check("count", count, mq.size());
        check("enq_ready", enq_ready, (DEPTH - mq.size()) >= 2);
        check("deq_valid_0", deq_valid_0, mq.size() >= 1);
        check("deq_valid_1", deq_valid_1, mq.size() >= 2);
        if (mq.size() >= 1) begin
            check("deq_pc_0", deq_pc_0, mq[0].pc);
            check("deq_instr_0", deq_instr_0, mq[0].instr);
            check("deq_pred_taken_0", deq_pred_taken_0, mq[0].pt);
            check("deq_pred_target_0", deq_pred_target_0, mq[0].tgt);
        end
        if (mq.size() >= 2) begin
            check("deq_pc_1", deq_pc_1, mq[1].pc);
            check("deq_instr_1", deq_instr_1, mq[1].instr);
            check("deq_pred_taken_1", deq_pred_taken_1, mq[1].pt);
            check("deq_pred_target_1", deq_pred_target_1, mq[1].tgt);
        end
    endtask

    task automatic drive(input bit v0, input bit v1, input logic [PW-1:0] p0,
                         input logic [PW-1:0] p1, input bit pt, input logic [PW-1:0] tgt,
                         input int dq, input bit fl);
        enq_valid_0     = v0;
        enq_valid_1     = v1;
        enq_pc_0        = p0;
        enq_pc_1        = p1;
        enq_instr_0     = $urandom;
        enq_instr_1     = $urandom;
        enq_pred_taken  = pt;
        enq_pred_target = tgt;
        deq_count       = 2'(dq);
        flush           = fl;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        logic [PW-1:0] pc;
        rst = 1'b1;
        drive(0, 0, '0, '0, 0, '0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_enq_ready", enq_ready, 1);
        check("rst_deq_valid_0", deq_valid_0, 0);
        check("rst_deq_valid_1", deq_valid_1, 0);
        check("rst_deq_pc_0", deq_pc_0, 0);
        check("rst_deq_instr_1", deq_instr_1, 0);
        check("rst_deq_target_1", deq_pred_target_1, 0);
        rst = 1'b0;

        // Two dual enqueues, no dequeue.
        drive(1, 1, 32'h0, 32'h4, 0, '0, 0, 0); step();
        drive(1, 1, 32'h8, 32'hC, 0, '0, 0, 0); step();
        check("t2_count", count, 4);
        check("t2_pc_0", deq_pc_0, 32'h0);
        check("t2_pc_1", deq_pc_1, 32'h4);

        // Fill to DEPTH, ignored enqueue while full, then drain two.
        drive(1, 1, 32'h10, 32'h14, 0, '0, 0, 0); step();
        drive(1, 1, 32'h18, 32'h1C, 0, '0, 0, 0); step();
        check("t3_full_count", count, 8);
        check("t3_full_ready", enq_ready, 0);
        drive(1, 1, 32'h20, 32'h24, 0, '0, 0, 0); step();
        check("t3_ignored_count", count, 8);
        drive(0, 0, '0, '0, 0, '0, 2, 0); step();
        check("t3_drain_count", count, 6);
        check("t3_drain_ready", enq_ready, 1);
        check("t3_drain_pc_0", deq_pc_0, 32'h8);

        // Only slot 1 valid into an empty queue lands at head without a prediction.
        drive(0, 0, '0, '0, 0, '0, 0, 1); step();
        drive(0, 1, 32'h0, 32'h14, 1, 32'hABC, 0, 0); step();
        check("t4_valid_0", deq_valid_0, 1);
        check("t4_pc_0", deq_pc_0, 32'h14);
        check("t4_valid_1", deq_valid_1, 0);
        check("t4_pred_taken_0", deq_pred_taken_0, 0);

        // Steady state with simultaneous enqueue and dequeue across pointer wrap.
        drive(1, 1, 32'h18, 32'h1C, 0, '0, 0, 0); step();
        check("t5_count3", count, 3);
        drive(1, 1, 32'h20, 32'h24, 0, '0, 1, 0); step();
        check("t5_count4", count, 4);
        check("t5_pc_0", deq_pc_0, 32'h18);
        pc = 32'h28;
        for (int i = 0; i < 24; i++) begin
            drive(1, 1, pc, pc + 4, i[0], pc + 32'h100, 2, 0); step();
            pc = pc + 8;
        end
        check("t5_wrap_count", count, 4);

        // Flush beats same-cycle enqueue/dequeue; a fresh prediction survives afterwards.
        drive(1, 0, pc, '0, 0, '0, 0, 0); step();
        check("t6_count5", count, 5);
        drive(1, 1, 32'h500, 32'h504, 1, 32'h900, 1, 1); step();
        check("t6_flush_count", count, 0);
        check("t6_flush_valid_0", deq_valid_0, 0);
        drive(1, 0, 32'h100, '0, 1, 32'h2000, 0, 0); step();
        check("t6_pred_taken_0", deq_pred_taken_0, 1);
        check("t6_pred_target_0", deq_pred_target_0, 32'h2000);

        // Randomized traffic, including occasional flushes and full-queue pressure.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom), $urandom,
                  $urandom_range(imin(2, mq.size()), 0), $urandom_range(19, 0) == 0);
            step();
        end

        // Asynchronous reset in the middle of traffic takes effect immediately.
        drive(1, 1, 32'h40, 32'h44, 1, 32'h80, 0, 0); step();
        drive(1, 1, 32'h48, 32'h4C, 0, '0, 1, 0);
        rst = 1'b1;
        #1;
        check("t1_count", count, 0);
        check("t1_deq_valid_0", deq_valid_0, 0);
        check("t1_deq_valid_1", deq_valid_1, 0);
        check("t1_enq_ready", enq_ready, 1);
        check("t1_deq_pc_0", deq_pc_0, 0);
        mq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare_all();
        drive(1, 1, 32'h60, 32'h64, 0, '0, 0, 0); step();
        check("t1_after_pc_0", deq_pc_0, 32'h60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
